aes_round_sequencer: RTL and testbench

Controller that sequences one AES block operation: it triggers key expansion, waits for the expanded key to settle, then issues round keys one per handshake to the cipher round datapath. The round count is selected by key size: 10, 12 or 14 rounds, with Nr+1 keys issued. It sits between the top-level command interface, the key expansion block (1920-bit expanded-key bus, MSB-first word order) and the round datapath.

---
 rtl/aes_round_sequencer.sv | 156 +++++++++++++++
 tb/tb_aes_round_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// AES round-key sequencer: triggers key expansion, then issues Nr+1 round keys.
// Optional descending key order for decryption via `AES_DECRYPT_ORDER_EN.
module aes_round_sequencer #(
    parameter int EXPAND_WAIT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      key_size,
    input  logic [0:1919]   key_exp,
`ifdef AES_DECRYPT_ORDER_EN
    input  logic            decrypt,
`endif
    output logic            key_exp_en,
    output logic [127:0]    round_key,
    output logic [3:0]      round_idx,
    output logic            round_valid,
    input  logic            round_ready,
    output logic            last_round,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        ISSUE,
        DONE
    } state_e;

    localparam logic [3:0] WAIT_LAST = 4'(EXPAND_WAIT - 1);

    state_e     state_q, state_d;
    logic [3:0] nr_q, nr_d;
    logic [3:0] wait_q, wait_d;
    logic [3:0] r_q, r_d;
    logic       dec_q, dec_d;
    logic       dec_in;
    logic [3:0] end_q, end_d;

    logic       en_q, en_d;
    logic       valid_q, valid_d;
    logic       last_q, last_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] idx_q, idx_d;

`ifdef AES_DECRYPT_ORDER_EN
    assign dec_in = decrypt;
`else
    assign dec_in = 1'b0;
`endif

    function automatic logic [3:0] nr_of(input logic [2:0] ks);
        case (ks)
            3'b010:  nr_of = 4'd12;
            3'b100:  nr_of = 4'd14;
            default: nr_of = 4'd10;
        endcase
    endfunction

    // Final key index: Nr ascending, 0 descending
    assign end_q = dec_q ? 4'd0 : nr_q;
    assign end_d = dec_d ? 4'd0 : nr_d;

    always_comb begin
        state_d = state_q;
        nr_d    = nr_q;
        wait_d  = wait_q;
        r_d     = r_q;
        dec_d   = dec_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    nr_d    = nr_of(key_size);
                    dec_d   = dec_in;
                    wait_d  = 4'd0;
                    r_d     = 4'd0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ISSUE;
                    r_d     = dec_q ? nr_q : 4'd0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ISSUE: begin
                if (round_ready) begin
                    if (r_q == end_q) begin
                        state_d = DONE;
                    end else if (dec_q) begin
                        r_d = r_q - 4'd1;
                    end else begin
                        r_d = r_q + 4'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state
    always_comb begin
        en_d    = (state_d == EXPAND);
        valid_d = (state_d == ISSUE);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
        idx_d   = valid_d ? r_d : 4'd0;
        last_d  = valid_d && (r_d == end_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            nr_q    <= 4'd10;
            wait_q  <= 4'd0;
            r_q     <= 4'd0;
            dec_q   <= 1'b0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            nr_q    <= nr_d;
            wait_q  <= wait_d;
            r_q     <= r_d;
            dec_q   <= dec_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    assign key_exp_en  = en_q;
    assign round_valid = valid_q;
    assign round_idx   = idx_q;
    assign last_round  = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign round_key   = valid_q ? key_exp[{idx_q, 7'd0} +: 128] : 128'd0;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: key order, timing, stalls, reset.
// Decrypt-order case is built only with `AES_DECRYPT_ORDER_EN.
module tb_aes_round_sequencer;

    localparam int W = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     key_size;
    logic [0:1919]  key_exp;
    logic           key_exp_en;
    logic [127:0]   round_key;
    logic [3:0]     round_idx;
    logic           round_valid;
    logic           round_ready;
    logic           last_round;
    logic           busy;
    logic           done;
`ifdef AES_DECRYPT_ORDER_EN
    logic           decrypt;
`endif

    int total = 0;
    int bad   = 0;
    int xfers = 0;
    int dones = 0;

    logic [132:0] sb[$];
    logic [132:0] e;
    bit           hold = 1'b0;
    logic [127:0] hkey;
    logic [3:0]   hidx;

    aes_round_sequencer #(.EXPAND_WAIT(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_size    (key_size),
        .key_exp     (key_exp),
`ifdef AES_DECRYPT_ORDER_EN
        .decrypt     (decrypt),
`endif
        .key_exp_en  (key_exp_en),
        .round_key   (round_key),
        .round_idx   (round_idx),
        .round_valid (round_valid),
        .round_ready (round_ready),
        .last_round  (last_round),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Known FIPS-197 round keys where listed, a filler pattern elsewhere
    function automatic logic [127:0] slot(input int nr, input int i);
        if (i == 0)
            return 128'h000102030405060708090a0b0c0d0e0f;
        if (nr == 10 && i == 10)
            return 128'h13111d7fe3944a17f307a78b4d2b30c5;
        if (nr == 14 && i == 1)
            return 128'h101112131415161718191a1b1c1d1e1f;
        if (nr == 14 && i == 14)
            return 128'h24fc79ccbf0979e9371ac23c6d68de36;
        if (nr == 12 && i == 12)
            return 128'ha4970a331a78dc09c418c271e3a41d5d;
        return {8{16'(i * 4099 + nr * 7 + 1)}};
    endfunction

    task automatic load(input int nr, input bit dec);
        int i;
        key_exp = '0;
        for (int s = 0; s < 15; s++)
            key_exp[128*s +: 128] = slot(nr, s);
        for (int j = 0; j <= nr; j++) begin
            i = dec ? nr - j : j;
            sb.push_back({(j == nr), 4'(i), slot(nr, i)});
        end
    endtask

    // Transfer monitor: pops the scoreboard on every handshake
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold && round_valid) begin
                    chk("hold_key", round_key, hkey);
                    chk("hold_idx", round_idx, hidx);
                end
                if (!round_valid)
                    chk("key_zero", round_key, 128'd0);
                if (round_valid && round_ready) begin
                    xfers++;
                    if (sb.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("idx", round_idx, e[131:128]);
                        chk("key", round_key, e[127:0]);
                        chk("last", last_round, e[132]);
                    end
                end
                if (done)
                    dones++;
                hold = round_valid && !round_ready;
                hkey = round_key;
                hidx = round_idx;
            end
        end
    end

    task automatic run(input logic [2:0] ks, input bit dec, input bit tog,
                       input bit disturb, input int exp_done);
        int nr;
        int x0;
        int d0;
        int dn;
        nr = (ks == 3'b010) ? 12 : (ks == 3'b100) ? 14 : 10;
        load(nr, dec);
        x0 = xfers;
        d0 = dones;
        dn = -1;
        for (int n = 0; n <= exp_done + 1; n++) begin
            @(posedge clk);
            #1;
            start = (n == 0) || (disturb && n == 6);
            if (n == 0)
                key_size = ks;
            if (disturb && n == 5)
                key_size = 3'b100;
`ifdef AES_DECRYPT_ORDER_EN
            if (n == 0)
                decrypt = dec;
`endif
            round_ready = tog ? (n % 2 == 0) : 1'b1;
            @(negedge clk);
            if (done)
                dn = n;
            if (!tog) begin
                chk("busy", busy, (n >= 1 && n <= exp_done));
                chk("kexp_en", key_exp_en, (n >= 1 && n <= W));
                chk("done", done, (n == exp_done));
            end
        end
        start = 1'b0;
        chk("done_cyc", dn, exp_done);
        chk("xfers", xfers - x0, nr + 1);
        chk("dones", dones - d0, 1);
        chk("sb_left", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int  d0;
        bit  got5;
        rst         = 1'b1;
        start       = 1'b0;
        key_size    = 3'b000;
        key_exp     = '0;
        round_ready = 1'b0;
`ifdef AES_DECRYPT_ORDER_EN
        decrypt     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_en", key_exp_en, 0);
        chk("rst_key", round_key, 0);
        chk("rst_idx", round_idx, 0);
        chk("rst_valid", round_valid, 0);
        chk("rst_last", last_round, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;

        run(3'b000, 1'b0, 1'b0, 1'b0, W + 10 + 2);
        run(3'b100, 1'b0, 1'b0, 1'b0, W + 14 + 2);
        run(3'b010, 1'b0, 1'b1, 1'b0, 29);
        run(3'b000, 1'b0, 1'b0, 1'b1, W + 10 + 2);

        // Abort mid-ISSUE with rst while idx 5 is on the bus
        load(10, 1'b0);
        @(posedge clk);
        #1;
        key_size    = 3'b000;
        round_ready = 1'b1;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        got5  = 1'b0;
        for (int n = 0; n < 30 && !got5; n++) begin
            @(negedge clk);
            if (round_valid && round_idx == 4'd5)
                got5 = 1'b1;
        end
        chk("reach_idx5", got5, 1);
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", round_valid, 0);
        chk("abort_key", round_key, 0);
        chk("abort_idx", round_idx, 0);
        chk("abort_last", last_round, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        sb.delete();
        d0 = dones;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_nodone", dones - d0, 0);
        chk("abort_idle", busy, 0);
        run(3'b000, 1'b0, 1'b0, 1'b0, W + 10 + 2);

`ifdef AES_DECRYPT_ORDER_EN
        run(3'b000, 1'b1, 1'b0, 1'b0, W + 10 + 2);
        run(3'b000, 1'b0, 1'b0, 1'b0, W + 10 + 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
